// File: rtl/mem_arbiter_if.sv
// Core/memory-side signal bundle for mem_arbiter; slave = arbiter view, master = core + memory view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (i_*) and load/store (d_*) ports, one access in flight.
// Define MEM_ARBITER_RR_EN for round-robin arbitration instead of d-priority with anti-starvation.
module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [2:0] LAT     = 3'(MEM_LAT);

  logic [1:0]    state_q, state_d;
  logic          win_i_q, win_i_d;
  logic [2:0]    wait_q, wait_d;
  logic          i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic          m_en_q, m_en_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          pick_i, take_i, take_d;

`ifdef MEM_ARBITER_RR_EN
  logic last_i_q, last_i_d;

  always_comb begin
    pick_i = ~last_i_q;
  end

  always_comb begin
    last_i_d = last_i_q;
    if (take_i)      last_i_d = 1'b1;
    else if (take_d) last_i_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_i_q <= 1'b1;
    else        last_i_q <= last_i_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  always_comb begin
    pick_i = (starve_q == STARVE_LIM);
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.i_req || take_i)                   starve_d = '0;
    else if (take_d && starve_q != STARVE_LIM)  starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  always_comb begin
    take_i = 1'b0;
    take_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.i_req && bus.d_req) begin
        take_i = pick_i;
        take_d = ~pick_i;
      end else begin
        take_i = bus.i_req;
        take_d = bus.d_req;
      end
    end
  end

  // Outputs are registered: the IDLE decision loads the ISSUE-cycle values directly,
  // so m_addr/m_wdata naturally hold between transactions.
  always_comb begin
    state_d    = state_q;
    win_i_d    = win_i_q;
    wait_d     = wait_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (take_i || take_d) begin
          state_d  = S_ISSUE;
          win_i_d  = take_i;
          m_en_d   = 1'b1;
          m_we_d   = take_d && bus.d_we;
          i_gnt_d  = take_i;
          d_gnt_d  = take_d;
          m_addr_d = take_i ? bus.i_addr : bus.d_addr;
          if (take_d) m_wdata_d = bus.d_wdata;
        end
      end
      S_ISSUE: begin
        if (m_we_q) begin
          state_d = S_IDLE;
        end else begin
          wait_d  = LAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 3'd1) begin
          state_d = S_RESP;
          if (win_i_q) begin
            i_rdata_d  = bus.m_rdata;
            i_rvalid_d = 1'b1;
          end else begin
            d_rdata_d  = bus.m_rdata;
            d_rvalid_d = 1'b1;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      win_i_q    <= 1'b0;
      wait_q     <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_i_q    <= win_i_d;
      wait_q     <= wait_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    bus.i_gnt    = i_gnt_q;
    bus.d_gnt    = d_gnt_q;
    bus.m_en     = m_en_q;
    bus.m_we     = m_we_q;
    bus.m_addr   = m_addr_q;
    bus.m_wdata  = m_wdata_q;
    bus.i_rvalid = i_rvalid_q;
    bus.d_rvalid = d_rvalid_q;
    bus.i_rdata  = i_rdata_q;
    bus.d_rdata  = d_rdata_q;
  end
endmodule
